// File: rtl/addr_mode_seq.sv
// addr_mode_seq: addressing-mode sequencer for the 65C816 address generator.
// Walks the per-mode cycle sequence one step per enabled clock. It drives the
// address/index/PC control codes and pulses done on the step where the
// effective address becomes final.
module addr_mode_seq #(
  parameter bit DP_PENALTY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       start,
  input  logic [2:0] mode,
  input  logic       abort,
  input  logic       dl_nz,
  input  logic       taken,
  input  logic       jump_no_ofl,
  input  logic       e6502,
  output logic [7:0] addr_ctrl,
  output logic [1:0] ind_ctrl,
  output logic [2:0] load_pc,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] M_ABS    = 3'd0;
  localparam logic [2:0] M_ABS_X  = 3'd1;
  localparam logic [2:0] M_ABS_Y  = 3'd2;
  localparam logic [2:0] M_DP     = 3'd3;
  localparam logic [2:0] M_DP_IND = 3'd4;
  localparam logic [2:0] M_LONG   = 3'd5;
  localparam logic [2:0] M_REL    = 3'd6;
  localparam logic [2:0] M_SR     = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE, S_OPL, S_OPH, S_OPB, S_IDX, S_DPA,
    S_SRA, S_PEN, S_ILO, S_IHI, S_BR, S_BRT
  } state_t;

  state_t     state_q, state_d, seq_next, first_step;
  logic [2:0] mode_q, mode_d;
  logic       pen_after_dpa;

  // The direct-page penalty cycle is only needed when D is not page aligned
  // and the core is in native mode.
  assign pen_after_dpa = DP_PENALTY && dl_nz && !e6502;

  // Entry step chosen from the incoming mode when a sequence is launched.
  always_comb begin
    first_step = S_IDLE;
    case (mode)
      M_ABS, M_ABS_X, M_ABS_Y, M_LONG: first_step = S_OPL;
      M_DP, M_DP_IND:                  first_step = S_DPA;
      M_REL:                           first_step = S_BR;
      M_SR:                            first_step = S_SRA;
      default:                         first_step = S_IDLE;
    endcase
  end

  // Successor step within a running sequence; S_IDLE means this is the last step.
  always_comb begin
    seq_next = S_IDLE;
    case (state_q)
      S_OPL: seq_next = S_OPH;
      S_OPH: begin
        if (mode_q == M_ABS_X || mode_q == M_ABS_Y) seq_next = S_IDX;
        else if (mode_q == M_LONG)                  seq_next = S_OPB;
        else                                        seq_next = S_IDLE;
      end
      S_DPA: begin
        if (pen_after_dpa)            seq_next = S_PEN;
        else if (mode_q == M_DP_IND)  seq_next = S_ILO;
        else                          seq_next = S_IDLE;
      end
      S_PEN: seq_next = (mode_q == M_DP_IND) ? S_ILO : S_IDLE;
      S_ILO: seq_next = S_IHI;
      S_SRA: seq_next = S_PEN;
      S_BR:  seq_next = taken ? S_BRT : S_IDLE;
      S_BRT: seq_next = (e6502 && !jump_no_ofl) ? S_PEN : S_IDLE;
      default: seq_next = S_IDLE;
    endcase
  end

  // Abort wins over launch and sequencing; start is honoured only from idle.
  always_comb begin
    state_d = seq_next;
    mode_d  = mode_q;
    if (abort) begin
      state_d = S_IDLE;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        state_d = first_step;
        mode_d  = mode;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // State and latched mode advance only on enabled edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 3'd0;
    end else if (en) begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Step control codes decoded from the registered state and latched mode.
  // done also looks at the branch/penalty qualifiers because the last step
  // of DP, DP_IND and REL depends on them; start never reaches any output.
  always_comb begin
    addr_ctrl = 8'h00;
    ind_ctrl  = 2'b00;
    load_pc   = 3'b000;
    case (state_q)
      S_OPL: begin addr_ctrl = 8'h40; load_pc = 3'b001; end
      S_OPH: begin addr_ctrl = 8'hEB; load_pc = 3'b001; end
      S_OPB: begin addr_ctrl = 8'hFD; load_pc = 3'b001; end
      S_IDX: begin
        addr_ctrl = 8'h24;
        ind_ctrl  = (mode_q == M_ABS_Y) ? 2'b01 : 2'b00;
      end
      S_DPA: begin addr_ctrl = 8'hB4; load_pc = 3'b001; end
      S_SRA: begin addr_ctrl = 8'hB7; load_pc = 3'b001; end
      S_PEN: addr_ctrl = 8'hFC;
      S_ILO: addr_ctrl = 8'h5C;
      S_IHI: addr_ctrl = 8'hEB;
      S_BR:  begin addr_ctrl = 8'hFC; load_pc = 3'b001; end
      S_BRT: begin addr_ctrl = 8'hFC; load_pc = 3'b100; end
      default: begin
        addr_ctrl = 8'h00;
        ind_ctrl  = 2'b00;
        load_pc   = 3'b000;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = busy && (seq_next == S_IDLE);

endmodule

// File: tb/tb_addr_mode_seq.sv
// tb_addr_mode_seq: directed and randomized checks of addr_mode_seq against
// a sequence-list model of each addressing mode.
module tb_addr_mode_seq;

  logic       clk = 1'b0;
  logic       rst_n, en, start, abort, dl_nz, taken, jump_no_ofl, e6502;
  logic [2:0] mode;
  logic [7:0] addr_ctrl;
  logic [1:0] ind_ctrl;
  logic [2:0] load_pc;
  logic       busy, done;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [7:0] a;
    logic [1:0] i;
    logic [2:0] p;
  } step_t;

  localparam step_t ST_IDLE = {8'h00, 2'b00, 3'b000};
  localparam step_t ST_OPL  = {8'h40, 2'b00, 3'b001};
  localparam step_t ST_OPH  = {8'hEB, 2'b00, 3'b001};
  localparam step_t ST_OPB  = {8'hFD, 2'b00, 3'b001};
  localparam step_t ST_IDXX = {8'h24, 2'b00, 3'b000};
  localparam step_t ST_IDXY = {8'h24, 2'b01, 3'b000};
  localparam step_t ST_DPA  = {8'hB4, 2'b00, 3'b001};
  localparam step_t ST_SRA  = {8'hB7, 2'b00, 3'b001};
  localparam step_t ST_PEN  = {8'hFC, 2'b00, 3'b000};
  localparam step_t ST_ILO  = {8'h5C, 2'b00, 3'b000};
  localparam step_t ST_IHI  = {8'hEB, 2'b00, 3'b000};
  localparam step_t ST_BR   = {8'hFC, 2'b00, 3'b001};
  localparam step_t ST_BRT  = {8'hFC, 2'b00, 3'b100};

  step_t exp_q[$];

  addr_mode_seq dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .mode(mode),
    .abort(abort), .dl_nz(dl_nz), .taken(taken), .jump_no_ofl(jump_no_ofl),
    .e6502(e6502), .addr_ctrl(addr_ctrl), .ind_ctrl(ind_ctrl),
    .load_pc(load_pc), .busy(busy), .done(done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected step list for one sequence with the qualifiers held constant.
  task automatic build_expected(input logic [2:0] m, input logic dz,
                                input logic tk, input logic jn, input logic em);
    exp_q.delete();
    case (m)
      3'd0: begin exp_q.push_back(ST_OPL); exp_q.push_back(ST_OPH); end
      3'd1: begin exp_q.push_back(ST_OPL); exp_q.push_back(ST_OPH); exp_q.push_back(ST_IDXX); end
      3'd2: begin exp_q.push_back(ST_OPL); exp_q.push_back(ST_OPH); exp_q.push_back(ST_IDXY); end
      3'd5: begin exp_q.push_back(ST_OPL); exp_q.push_back(ST_OPH); exp_q.push_back(ST_OPB); end
      3'd3: begin
        exp_q.push_back(ST_DPA);
        if (dz && !em) exp_q.push_back(ST_PEN);
      end
      3'd4: begin
        exp_q.push_back(ST_DPA);
        if (dz && !em) exp_q.push_back(ST_PEN);
        exp_q.push_back(ST_ILO);
        exp_q.push_back(ST_IHI);
      end
      3'd7: begin exp_q.push_back(ST_SRA); exp_q.push_back(ST_PEN); end
      default: begin
        exp_q.push_back(ST_BR);
        if (tk) begin
          exp_q.push_back(ST_BRT);
          if (em && !jn) exp_q.push_back(ST_PEN);
        end
      end
    endcase
  endtask

  // Compare every output against the expected step, busy and done.
  task automatic check_output(input string tag, input step_t s,
                              input logic b, input logic d);
    compared++;
    assert ({addr_ctrl, ind_ctrl, load_pc, busy, done} === {s, b, d})
    else begin
      mismatched++;
      $error("[TB] FAIL %s: got addr=%h ind=%b pc=%b busy=%b done=%b, want addr=%h ind=%b pc=%b busy=%b done=%b",
             tag, addr_ctrl, ind_ctrl, load_pc, busy, done, s.a, s.i, s.p, b, d);
    end
  endtask

  // Launch one sequence and follow it to idle, optionally toggling en and
  // driving junk start/mode while busy.
  task automatic apply_stimulus(input logic [2:0] m, input logic dz, input logic tk,
                                input logic jn, input logic em,
                                input bit rand_en, input bit noise);
    int idx;
    int cycles;
    build_expected(m, dz, tk, jn, em);
    dl_nz = dz; taken = tk; jump_no_ofl = jn; e6502 = em;
    en = 1'b1; start = 1'b1; mode = m;
    tick();
    start = 1'b0;
    idx = 0;
    cycles = 0;
    while (idx < exp_q.size() && cycles < 200) begin
      check_output($sformatf("mode%0d_step%0d", m, idx), exp_q[idx], 1'b1,
                   idx == exp_q.size() - 1);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        mode  = 3'($urandom);
      end
      en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (en) idx++;
      cycles++;
    end
    if (idx < exp_q.size()) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL timeout mode%0d: reached step %0d of %0d", m, idx, exp_q.size());
    end
    start = 1'b0; en = 1'b1; mode = 3'd0;
    check_output($sformatf("mode%0d_idle", m), ST_IDLE, 1'b0, 1'b0);
  endtask

  // Directed scenarios followed by randomized sequences.
  initial begin
    rst_n = 1'b0; en = 1'b1; start = 1'b1; mode = 3'd3; abort = 1'b0;
    dl_nz = 1'b0; taken = 1'b0; jump_no_ofl = 1'b0; e6502 = 1'b0;
    tick();
    tick();
    check_output("reset_start_high", ST_IDLE, 1'b0, 1'b0);
    rst_n = 1'b1;

    apply_stimulus(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    en = 1'b0; start = 1'b1; mode = 3'd1;
    tick();
    check_output("start_en_low", ST_IDLE, 1'b0, 1'b0);

    apply_stimulus(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(3'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(3'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    start = 1'b1; mode = 3'd5;
    tick();
    start = 1'b0;
    check_output("long_step0", ST_OPL, 1'b1, 1'b0);
    tick();
    check_output("long_step1", ST_OPH, 1'b1, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_output("abort_idle", ST_IDLE, 1'b0, 1'b0);
    start = 1'b1; mode = 3'd0;
    tick();
    start = 1'b0;
    check_output("post_abort_step0", ST_OPL, 1'b1, 1'b0);
    tick();
    check_output("post_abort_step1", ST_OPH, 1'b1, 1'b1);
    tick();
    check_output("post_abort_idle", ST_IDLE, 1'b0, 1'b0);

    start = 1'b1; mode = 3'd4; dl_nz = 1'b1; e6502 = 1'b0;
    tick();
    start = 1'b0;
    check_output("dpind_step0", ST_DPA, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_output("mid_reset_idle", ST_IDLE, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      apply_stimulus(3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
